// File: rtl/delay_path_prober_pkg.sv
// rtl/delay_path_prober_pkg.sv - shared sensor types and default sizes for the delay-chain prober
package delay_path_prober_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SETTLE,
      CAPTURE,
      DONE
   } prober_state_t;

   localparam int DEFAULT_WINDOW   = 1024;
   localparam int DEFAULT_CNT_W    = 16;
   localparam int DEFAULT_SETTLE_W = 4;

endpackage

// File: rtl/delay_path_prober_sat_counter.sv
// rtl/delay_path_prober_sat_counter.sv - saturating up-counter with synchronous clear and enable
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/delay_path_prober.sv
// rtl/delay_path_prober.sv - launch/capture controller counting late or wrong delay-chain captures
module delay_path_prober
   import delay_path_prober_pkg::*;
#(
   parameter int WINDOW     = DEFAULT_WINDOW,
   parameter int CNT_W      = DEFAULT_CNT_W,
   parameter int SETTLE_W   = DEFAULT_SETTLE_W,
   parameter bit EXPECT_INV = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SETTLE_W-1:0] settle_cycles,
   output logic                path_in,
   input  logic                path_out,
   output logic                busy,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [CNT_W-1:0]    fail_count
);

   localparam int LW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   prober_state_t       state;
   prober_state_t       nextState;
   logic                enterLaunch;
   logic                clearCnt;
   logic                doCapture;
   logic                pathInQ;
   logic                expectQ;
   logic                pathOutQ;
   logic [SETTLE_W-1:0] settleLat;
   logic [SETTLE_W-1:0] settleCnt;
   logic [SETTLE_W-1:0] startSettle;
   logic [SETTLE_W-1:0] settleLoad;
   logic [LW-1:0]       launchCnt;

   assign startSettle = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
   assign settleLoad  = (state == IDLE) ? startSettle : settleLat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // The toggle is registered on the edge entering LAUNCH, so LAUNCH itself is the first settle clock.
   always_comb begin
      nextState   = state;
      enterLaunch = 1'b0;
      clearCnt    = 1'b0;
      doCapture   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState   = LAUNCH;
               enterLaunch = 1'b1;
               clearCnt    = 1'b1;
            end
         end
         LAUNCH, SETTLE: begin
            if (settleCnt == SETTLE_W'(1)) begin
               nextState = CAPTURE;
            end else begin
               nextState = SETTLE;
            end
         end
         CAPTURE: begin
            doCapture = 1'b1;
            if (launchCnt == LW'(WINDOW - 1)) begin
               nextState = DONE;
            end else begin
               nextState   = LAUNCH;
               enterLaunch = 1'b1;
            end
         end
         DONE: begin
            if (result_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pathInQ   <= 1'b0;
         expectQ   <= 1'b0;
         pathOutQ  <= 1'b0;
         settleLat <= '0;
         settleCnt <= '0;
         launchCnt <= '0;
      end else begin
         pathOutQ <= path_out;
         if (clearCnt) begin
            settleLat <= startSettle;
         end
         if (enterLaunch) begin
            pathInQ   <= ~pathInQ;
            expectQ   <= ~pathInQ ^ EXPECT_INV;
            settleCnt <= settleLoad;
         end else if ((state == LAUNCH) || (state == SETTLE)) begin
            settleCnt <= settleCnt - SETTLE_W'(1);
         end
         if (clearCnt) begin
            launchCnt <= '0;
         end else if (doCapture) begin
            launchCnt <= launchCnt + LW'(1);
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_failCounter (
      .clk  (clk),
      .rst  (rst),
      .clr  (clearCnt),
      .en   (doCapture && (pathOutQ != expectQ)),
      .count(fail_count)
   );

   assign path_in      = pathInQ;
   assign busy         = (state != IDLE);
   assign result_valid = (state == DONE);

endmodule

// File: tb/tb_delay_path_prober.sv
// tb/tb_delay_path_prober.sv - randomized bench for delay_path_prober with a timeline reference model
module tb_delay_path_prober;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [3:0]  settle = 4'd0;
   logic        ready = 1'b0;
   int          dly = 1;
   logic        cinv = 1'b0;

   logic [2:0]  pathIn;
   logic [2:0]  pathOut;
   logic [2:0]  busy;
   logic [2:0]  rv;
   logic [15:0] fcA;
   logic [7:0]  fcB;
   logic [15:0] fcC;
   logic [7:0]  hist [3];

   int   checks = 0;
   int   errors = 0;
   int   winOf [3] = '{8, 300, 4};
   int   maxOf [3] = '{65535, 255, 65535};
   bit   eiOf  [3] = '{1'b0, 1'b1, 1'b0};
   logic lvl   [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   // Chain model: lag of dly clocks (0 = combinational) plus optional inversion.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) hist[k] <= {hist[k][6:0], pathIn[k]};
   end

   function automatic logic chainOut(input logic pi, input logic [7:0] h);
      logic v;
      v = (dly == 0) ? pi : h[dly-1];
      return v ^ cinv;
   endfunction

   assign pathOut[0] = chainOut(pathIn[0], hist[0]);
   assign pathOut[1] = chainOut(pathIn[1], hist[1]);
   assign pathOut[2] = chainOut(pathIn[2], hist[2]);

   delay_path_prober #(.WINDOW(8), .CNT_W(16), .SETTLE_W(4), .EXPECT_INV(1'b0)) dutA (
      .clk(clk), .rst(rst), .start(start && (sel == 2'd0)), .settle_cycles(settle),
      .path_in(pathIn[0]), .path_out(pathOut[0]), .busy(busy[0]), .result_valid(rv[0]),
      .result_ready(ready), .fail_count(fcA));

   delay_path_prober #(.WINDOW(300), .CNT_W(8), .SETTLE_W(4), .EXPECT_INV(1'b1)) dutB (
      .clk(clk), .rst(rst), .start(start && (sel == 2'd1)), .settle_cycles(settle),
      .path_in(pathIn[1]), .path_out(pathOut[1]), .busy(busy[1]), .result_valid(rv[1]),
      .result_ready(ready), .fail_count(fcB));

   delay_path_prober #(.WINDOW(4), .CNT_W(16), .SETTLE_W(4), .EXPECT_INV(1'b0)) dutC (
      .clk(clk), .rst(rst), .start(start && (sel == 2'd2)), .settle_cycles(settle),
      .path_in(pathIn[2]), .path_out(pathOut[2]), .busy(busy[2]), .result_valid(rv[2]),
      .result_ready(ready), .fail_count(fcC));

   function automatic logic [15:0] getFc(input int i);
      case (i)
         0: return fcA;
         1: return {8'd0, fcB};
         default: return fcC;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // path_in level after edge t of a measurement (t=0 is the edge that accepts start).
   function automatic logic levelAt(input int t, input logic init, input int s, input int w);
      int tog;
      if (t < 0) return init;
      tog = t / (s + 1) + 1;
      if (tog > w) tog = w;
      return init ^ logic'(tog % 2);
   endfunction

   function automatic logic [15:0] expFails(input logic init, input int s, input int w,
                                            input bit ei, input int maxv);
      int   cnt = 0;
      int   t;
      logic newL;
      logic samp;
      for (int k = 0; k < w; k++) begin
         t    = k * (s + 1) + s;
         newL = init ^ logic'((k + 1) % 2);
         samp = levelAt(t - 1 - dly, init, s, w) ^ cinv;
         if (samp != (newL ^ ei)) cnt++;
      end
      if (cnt > maxv) cnt = maxv;
      return 16'(cnt);
   endfunction

   task automatic measure(input int i, input int s, input string tag);
      int          seff;
      int          lat;
      int          n;
      logic [15:0] ef;
      seff = (s == 0) ? 1 : s;
      lat  = 1 + winOf[i] * (seff + 1);
      repeat (6) @(negedge clk);
      ef     = expFails(lvl[i], seff, winOf[i], eiOf[i], maxOf[i]);
      sel    = 2'(i);
      settle = 4'(s);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 1;
      check({tag, "_busy_rise"}, 32'(busy[i]), 32'd1);
      while (!rv[i] && (n < lat + 20)) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_fail_count"}, 32'(getFc(i)), 32'(ef));
      lvl[i] = lvl[i] ^ logic'(winOf[i] % 2);
   endtask

   task automatic accept(input int i, input string tag);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(rv[i]), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy[i]), 32'd0);
   endtask

   initial begin
      logic [15:0] held;
      int          n;
      repeat (3) @(negedge clk);
      check("reset_path_in", 32'(pathIn), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(rv), 32'd0);
      check("reset_fail_count", 32'(fcA | getFc(1) | fcC), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      dly = 1; cinv = 1'b0;
      measure(0, 2, "ideal");
      check("ideal_zero_fails", 32'(fcA), 32'd0);
      accept(0, "ideal");

      dly = 4;
      measure(0, 2, "slow");
      check("slow_all_fail", 32'(fcA), 32'd8);
      held = fcA;
      for (int j = 0; j < 10; j++) begin
         start = (j % 3 == 0);
         @(negedge clk);
         check("bp_valid_hold", 32'(rv[0]), 32'd1);
         check("bp_count_hold", 32'(fcA), 32'(held));
      end
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ready = 1'b0;
      check("bp_accept_valid", 32'(rv[0]), 32'd0);
      check("bp_accept_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      check("bp_start_ignored", 32'(busy[0]), 32'd0);

      dly = 0; cinv = 1'b0;
      measure(1, 1, "sat");
      check("sat_all_ones", 32'(fcB), 32'd255);
      accept(1, "sat");
      cinv = 1'b1;
      measure(1, 1, "inv_ok");
      accept(1, "inv_ok");

      dly = 0; cinv = 1'b0;
      ready = 1'b1;
      measure(2, 0, "settle0");
      @(negedge clk);
      check("settle0_valid_one_cycle", 32'(rv[2]), 32'd0);
      check("settle0_busy_low", 32'(busy[2]), 32'd0);
      ready = 1'b0;

      dly = 4;
      repeat (6) @(negedge clk);
      sel = 2'd0; settle = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 14) begin
         @(negedge clk);
         n++;
      end
      check("midrst_busy_before", 32'(busy[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_path_in", 32'(pathIn[0]), 32'd0);
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_valid", 32'(rv[0]), 32'd0);
      check("midrst_fail_count", 32'(fcA), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) lvl[k] = 1'b0;
      dly = 1;
      measure(0, 2, "post_rst");
      accept(0, "post_rst");

      for (int r = 0; r < 8; r++) begin
         int inst;
         int s;
         inst = (r % 2 == 0) ? 0 : 2;
         s    = int'($urandom_range(0, 4));
         dly  = int'($urandom_range(0, 5));
         cinv = logic'($urandom_range(0, 1));
         measure(inst, s, "rand");
         accept(inst, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
